// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the memory controller and its helpers.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    localparam lc3b_mem_wmask WMASK_NONE = 2'b00;
    localparam lc3b_mem_wmask WMASK_FULL = 2'b11;

endpackage

// File: rtl/mem_byte_merge.sv
// Per-lane merge of a partial CPU write into the word read back from memory.
module mem_byte_merge
    import lc3b_types::*;
(
    input  lc3b_word      old_i,
    input  lc3b_word      new_i,
    input  lc3b_mem_wmask mask_i,
    output lc3b_word      merged_o
);

    always_comb begin
        merged_o[15:8] = mask_i[1] ? new_i[15:8] : old_i[15:8];
        merged_o[7:0]  = mask_i[0] ? new_i[7:0]  : old_i[7:0];
    end

endmodule

// File: rtl/mem_ctrl.sv
// CPU-to-physical-memory controller with a one-word read buffer and
// read-modify-write handling of partial (single byte lane) stores.
module mem_ctrl
    import lc3b_types::*;
#(
    parameter bit BUF_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    output lc3b_word      mem_rdata,
    output logic          mem_resp,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    input  lc3b_word      pmem_rdata,
    input  logic          pmem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [14:0]   addr_q;
    lc3b_word      wdata_q;
    lc3b_mem_wmask be_q;
    lc3b_word      rdata_q;
    logic          buf_valid_q;
    logic [14:0]   buf_tag_q;
    lc3b_word      buf_data_q;
    lc3b_word      merged;
    logic          buf_hit;
    logic          wr_hit;
    logic          unused_addr_lsb;

    // Byte offset is irrelevant: memory is word-organised.
    assign unused_addr_lsb = mem_address[0];

    assign buf_hit = BUF_EN && buf_valid_q && (buf_tag_q == mem_address[15:1]);
    assign wr_hit  = buf_valid_q && (buf_tag_q == addr_q);

    mem_byte_merge u_merge (
        .old_i    (pmem_rdata),
        .new_i    (wdata_q),
        .mask_i   (be_q),
        .merged_o (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_write) begin
                    if (mem_byte_enable == WMASK_FULL)      state_d = WR;
                    else if (mem_byte_enable == WMASK_NONE) state_d = DONE;
                    else                                    state_d = RMW_RD;
                end else if (mem_read) begin
                    state_d = buf_hit ? DONE : RD;
                end
            end
            RD:      if (pmem_resp) state_d = DONE;
            WR:      if (pmem_resp) state_d = DONE;
            RMW_RD:  if (pmem_resp) state_d = RMW_WR;
            RMW_WR:  if (pmem_resp) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by rst so nothing is visible while reset is held.
    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        if (!rst) begin
            mem_resp   = (state_q == DONE);
            pmem_read  = (state_q == RD) || (state_q == RMW_RD);
            pmem_write = (state_q == WR) || (state_q == RMW_WR);
        end
    end

    assign pmem_address = {addr_q, 1'b0};
    assign pmem_wdata   = wdata_q;
    assign mem_rdata    = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= mem_address[15:1];
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                        if (!mem_write && buf_hit) rdata_q <= buf_data_q;
                    end
                end
                RD: begin
                    if (pmem_resp) begin
                        rdata_q <= pmem_rdata;
                        if (BUF_EN) begin
                            buf_valid_q <= 1'b1;
                            buf_tag_q   <= addr_q;
                            buf_data_q  <= pmem_rdata;
                        end
                    end
                end
                // The merged word replaces the latched write data for RMW_WR.
                RMW_RD: if (pmem_resp) wdata_q <= merged;
                WR, RMW_WR: if (pmem_resp && wr_hit) buf_data_q <= wdata_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: acts as the CPU and as a latency-programmable pmem.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    mem_ctrl #(.BUF_EN(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [15:0] mem_model [logic [15:0]];

    int          nrd, nwr, resp_cyc, addr_err, both_err, first_op;
    logic        got;
    logic [15:0] rdata_seen, last_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // One CPU transaction; pmem answers lat cycles after each strobe is seen.
    task automatic run(input string tag, input logic rd, input logic wr, input logic [1:0] be,
                       input logic [15:0] addr, input logic [15:0] wdata, input int lat,
                       input logic scramble);
        int cnt;
        int n;
        logic [15:0] waddr;
        waddr = {addr[15:1], 1'b0};
        nrd = 0; nwr = 0; resp_cyc = 0; addr_err = 0; both_err = 0; first_op = 0;
        got = 1'b0; cnt = 0; n = 0;
        mem_read = rd; mem_write = wr; mem_byte_enable = be;
        mem_address = addr; mem_wdata = wdata;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            pmem_resp = 1'b0;
            if (scramble && n == 1) begin
                mem_address = ~addr; mem_wdata = ~wdata; mem_byte_enable = ~be;
            end
            if (mem_resp) begin
                got = 1'b1; resp_cyc = n; rdata_seen = mem_rdata;
            end else if (pmem_read || pmem_write) begin
                if (pmem_read && pmem_write) both_err++;
                if (pmem_address !== waddr) addr_err++;
                cnt++;
                if (cnt == lat) begin
                    if (pmem_read) begin
                        pmem_rdata = mem_model.exists(pmem_address) ? mem_model[pmem_address] : 16'h0000;
                        nrd++;
                        if (first_op == 0) first_op = 1;
                    end else begin
                        mem_model[pmem_address] = pmem_wdata;
                        last_w = pmem_wdata;
                        nwr++;
                        if (first_op == 0) first_op = 2;
                    end
                    pmem_resp = 1'b1;
                    cnt = 0;
                end
            end
        end
        chk({tag, "_resp_seen"}, {31'd0, got}, 32'd1);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk({tag, "_resp_one_cycle"}, {31'd0, mem_resp}, 32'd0);
        chk({tag, "_pmem_addr"}, addr_err, 0);
        chk({tag, "_strobe_excl"}, both_err, 0);
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
        mem_address = 16'h0; mem_wdata = 16'h0; pmem_rdata = 16'h0; pmem_resp = 1'b0;
        last_w = 16'h0; rdata_seen = 16'h0;
        mem_model[16'h3000] = 16'hBEEF;
        mem_model[16'h4000] = 16'h1234;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_resp", {31'd0, mem_resp}, 0);
        chk("rst_pmem_read", {31'd0, pmem_read}, 0);
        chk("rst_pmem_write", {31'd0, pmem_write}, 0);
        chk("rst_mem_rdata", {16'd0, mem_rdata}, 0);
        chk("rst_pmem_address", {16'd0, pmem_address}, 0);
        chk("rst_pmem_wdata", {16'd0, pmem_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Read miss, 3-cycle latency
        run("rd_miss", 1, 0, 2'b00, 16'h3001, 16'h0, 3, 0);
        chk("rd_miss_data", {16'd0, rdata_seen}, 32'hBEEF);
        chk("rd_miss_nrd", nrd, 1);
        chk("rd_miss_nwr", nwr, 0);
        chk("rd_miss_cyc", resp_cyc, 4);

        // Buffer hit
        run("rd_hit", 1, 0, 2'b00, 16'h3000, 16'h0, 1, 0);
        chk("rd_hit_data", {16'd0, rdata_seen}, 32'hBEEF);
        chk("rd_hit_nrd", nrd, 0);
        chk("rd_hit_cyc", resp_cyc, 1);

        // Upper-lane partial write: read-modify-write
        run("rmw_hi", 0, 1, 2'b10, 16'h4000, 16'hAB00, 2, 0);
        chk("rmw_hi_nrd", nrd, 1);
        chk("rmw_hi_nwr", nwr, 1);
        chk("rmw_hi_order", first_op, 1);
        chk("rmw_hi_wdata", {16'd0, last_w}, 32'hAB34);
        chk("rmw_hi_cyc", resp_cyc, 5);
        chk("rmw_hi_rdata_kept", {16'd0, mem_rdata}, 32'hBEEF);

        // Lower-lane partial write with inputs changed after acceptance
        run("rmw_lo", 0, 1, 2'b01, 16'h4001, 16'h00CD, 1, 1);
        chk("rmw_lo_nrd", nrd, 1);
        chk("rmw_lo_nwr", nwr, 1);
        chk("rmw_lo_wdata", {16'd0, last_w}, 32'hABCD);

        // Full write to the buffered word, then read it back from the buffer
        run("wr_full", 0, 1, 2'b11, 16'h3000, 16'h5555, 1, 0);
        chk("wr_full_nrd", nrd, 0);
        chk("wr_full_nwr", nwr, 1);
        chk("wr_full_wdata", {16'd0, last_w}, 32'h5555);
        chk("wr_full_cyc", resp_cyc, 2);
        run("rd_coherent", 1, 0, 2'b00, 16'h3000, 16'h0, 1, 0);
        chk("rd_coherent_data", {16'd0, rdata_seen}, 32'h5555);
        chk("rd_coherent_nrd", nrd, 0);

        // Read and write together, empty mask: write wins, no access
        run("both_be0", 1, 1, 2'b00, 16'h3000, 16'hFFFF, 1, 0);
        chk("both_be0_nrd", nrd, 0);
        chk("both_be0_nwr", nwr, 0);
        chk("both_be0_cyc", resp_cyc, 1);
        chk("both_be0_rdata", {16'd0, mem_rdata}, 32'h5555);

        // Read and write together, full mask: becomes a write
        run("both_be3", 1, 1, 2'b11, 16'h6000, 16'h0F0F, 1, 0);
        chk("both_be3_nrd", nrd, 0);
        chk("both_be3_nwr", nwr, 1);
        chk("both_be3_wdata", {16'd0, last_w}, 32'h0F0F);

        // Reset during a read miss, then a stray pmem_resp
        mem_read = 1'b1; mem_address = 16'h7000;
        @(negedge clk);
        chk("abort_rd_strobe", {31'd0, pmem_read}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strobe_rd", {31'd0, pmem_read}, 0);
        chk("abort_strobe_wr", {31'd0, pmem_write}, 0);
        chk("abort_resp", {31'd0, mem_resp}, 0);
        rst = 1'b0; mem_read = 1'b0; pmem_rdata = 16'hDEAD; pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("late_resp_mem_resp", {31'd0, mem_resp}, 0);
        chk("late_resp_strobe", {31'd0, pmem_read | pmem_write}, 0);
        chk("late_resp_rdata", {16'd0, mem_rdata}, 0);
        @(negedge clk);
        chk("late_resp_mem_resp2", {31'd0, mem_resp}, 0);
        run("rd_after_rst", 1, 0, 2'b00, 16'h3000, 16'h0, 1, 0);
        chk("rd_after_rst_nrd", nrd, 1);
        chk("rd_after_rst_data", {16'd0, rdata_seen}, 32'h5555);
        chk("rd_after_rst_cyc", resp_cyc, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
